// File: rtl/kw_asym_fifo_s1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : kw_asym_fifo_s1                                                  |
// | Brief   : Single-clock FWFT FIFO with narrow/wide packing and unpacking.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module kw_asym_fifo_s1 #(
    parameter int DATA_I_WIDTH = 32,
    parameter int DATA_O_WIDTH = 32,
    parameter int DEPTH        = 16,
    parameter int AE_LEVEL     = 1,
    parameter int AF_LEVEL     = 1,
    parameter int ERR_MODE     = 0,
    parameter int WORD_ORDER   = 0
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push_req_n,
    input  logic                         pop_req_n,
    input  logic                         flush_n,
    input  logic [DATA_I_WIDTH-1:0]      data_in,
    output logic [DATA_O_WIDTH-1:0]      data_out,
    output logic                         empty,
    output logic                         almost_empty,
    output logic                         half_full,
    output logic                         almost_full,
    output logic                         ram_full,
    output logic                         full,
    output logic                         part_wr,
    output logic                         error,
    output logic [$clog2(DEPTH+1)-1:0]   word_count
);

    localparam int c_rw = (DATA_I_WIDTH > DATA_O_WIDTH) ? DATA_I_WIDTH : DATA_O_WIDTH;
    localparam int c_nw = (DATA_I_WIDTH > DATA_O_WIDTH) ? DATA_O_WIDTH : DATA_I_WIDTH;
    localparam int c_k  = c_rw / c_nw;
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH + 1);
    localparam bit c_lsb_first = (WORD_ORDER != 0);
    localparam logic [c_aw-1:0] c_plast = c_aw'(DEPTH - 1);
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_ae    = c_cw'(AE_LEVEL);
    localparam logic [c_cw-1:0] c_half  = c_cw'(DEPTH / 2);
    localparam logic [c_cw-1:0] c_af    = c_cw'(DEPTH - AF_LEVEL);

    logic [c_rw-1:0] r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_cw-1:0] r_count;

    logic            w_push, w_pop, w_empty, w_ram_full, w_pop_ok;
    logic            w_word_free, w_ram_wr, w_push_ok, w_flush_rej, w_err_evt;
    logic [c_rw-1:0] w_wr_data, w_head;
    logic            w_unused;

    assign w_push     = !push_req_n;
    assign w_pop      = !pop_req_n;
    assign w_empty    = (r_count == '0);
    assign w_ram_full = (r_count == c_depth);
    assign w_pop_ok   = w_pop && !w_empty;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_err_evt  = (w_push && !w_push_ok) || (w_pop && w_empty) || w_flush_rej;
    // Inputs that only matter in some width configurations.
    assign w_unused   = flush_n ^ c_lsb_first;

    generate
        if (DATA_I_WIDTH < DATA_O_WIDTH) begin : g_pack
            localparam int c_kw = $clog2(c_k);
            localparam logic [c_kw-1:0] c_klast = c_kw'(c_k - 1);
            logic [c_kw-1:0] r_pack_cnt;
            logic [c_rw-1:0] r_pack;
            logic [c_rw-1:0] w_din_placed;
            logic            w_last, w_room, w_flush_act;
            int              w_slot;

            assign w_last      = (r_pack_cnt == c_klast);
            assign w_room      = !w_ram_full || w_word_free;
            assign w_flush_act = !flush_n && ((r_pack_cnt != '0) || w_push);

            always_comb begin
                w_din_placed = '0;
                w_slot = c_lsb_first ? int'(r_pack_cnt) : (c_k - 1 - int'(r_pack_cnt));
                for (int j = 0; j < c_k; j++) begin
                    if (j == w_slot) begin
                        w_din_placed[j*DATA_I_WIDTH +: DATA_I_WIDTH] = data_in;
                    end
                end
            end

            // A flush claims the RAM slot, so it gates this cycle's push as well.
            assign w_push_ok   = w_push && (w_flush_act ? w_room : (!(w_ram_full && w_last) || w_word_free));
            assign w_flush_rej = w_flush_act && !w_room;
            assign w_ram_wr    = (w_flush_act && w_room) || (w_push_ok && w_last);
            assign w_wr_data   = r_pack | (w_push_ok ? w_din_placed : '0);
            assign full        = w_ram_full && w_last;
            assign part_wr     = (r_pack_cnt != '0);

            // Packer is cleared on every RAM write so unused slots read as zero.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_pack_cnt <= '0;
                    r_pack     <= '0;
                end else if (w_ram_wr) begin
                    r_pack_cnt <= '0;
                    r_pack     <= '0;
                end else if (w_push_ok) begin
                    r_pack_cnt <= r_pack_cnt + 1'b1;
                    r_pack     <= r_pack | w_din_placed;
                end
            end
        end else begin : g_nopack
            assign w_push_ok   = w_push && (!w_ram_full || w_word_free);
            assign w_flush_rej = 1'b0;
            assign w_ram_wr    = w_push_ok;
            assign w_wr_data   = data_in;
            assign full        = w_ram_full;
            assign part_wr     = 1'b0;
        end
    endgenerate

    generate
        if (DATA_I_WIDTH > DATA_O_WIDTH) begin : g_unpack
            localparam int c_kw = $clog2(c_k);
            localparam logic [c_kw-1:0] c_klast = c_kw'(c_k - 1);
            logic [c_kw-1:0]         r_idx;
            logic [DATA_O_WIDTH-1:0] w_sel;
            int                      w_pos;

            assign w_word_free = w_pop_ok && (r_idx == c_klast);

            always_comb begin
                w_sel = '0;
                w_pos = c_lsb_first ? int'(r_idx) : (c_k - 1 - int'(r_idx));
                for (int j = 0; j < c_k; j++) begin
                    if (j == w_pos) begin
                        w_sel = w_head[j*DATA_O_WIDTH +: DATA_O_WIDTH];
                    end
                end
            end

            assign data_out = w_empty ? '0 : w_sel;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_idx <= '0;
                end else if (w_pop_ok) begin
                    r_idx <= (r_idx == c_klast) ? '0 : r_idx + 1'b1;
                end
            end
        end else begin : g_nounpack
            assign w_word_free = w_pop_ok;
            assign data_out    = w_empty ? '0 : w_head;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (w_ram_wr) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_ram_wr) begin
                r_wr_ptr <= (r_wr_ptr == c_plast) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_word_free) begin
                r_rd_ptr <= (r_rd_ptr == c_plast) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_ram_wr && !w_word_free) begin
                r_count <= r_count + 1'b1;
            end else if (!w_ram_wr && w_word_free) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    generate
        if (ERR_MODE == 0) begin : g_err_sticky
            logic r_err;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_err <= 1'b0;
                end else if (w_err_evt) begin
                    r_err <= 1'b1;
                end
            end
            assign error = r_err;
        end else begin : g_err_comb
            assign error = w_err_evt;
        end
    endgenerate

    assign empty        = w_empty;
    assign almost_empty = (r_count <= c_ae);
    assign half_full    = (r_count >= c_half);
    assign almost_full  = (r_count >= c_af);
    assign ram_full     = w_ram_full;
    assign word_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_kw_asym_fifo_s1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_kw_asym_fifo_s1                                               |
// | Brief   : Scoreboard bench for plain, packing and unpacking FIFO configs.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_kw_asym_fifo_s1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    // A: 8 -> 8, depth 4, sticky error
    logic       a_push_n = 1'b1, a_pop_n = 1'b1, a_flush_n = 1'b1;
    logic [7:0] a_din = '0, a_dout;
    logic       a_empty, a_ae, a_hf, a_af, a_rf, a_full, a_pw, a_err;
    logic [2:0] a_cnt;
    // B: 8 -> 32, depth 4, first sub-word in MSBs, sticky error
    logic        b_push_n = 1'b1, b_pop_n = 1'b1, b_flush_n = 1'b1;
    logic [7:0]  b_din = '0;
    logic [31:0] b_dout;
    logic        b_empty, b_ae, b_hf, b_af, b_rf, b_full, b_pw, b_err;
    logic [2:0]  b_cnt;
    // C: 32 -> 8, depth 4, first sub-word in LSBs, combinational error
    logic        c_push_n = 1'b1, c_pop_n = 1'b1, c_flush_n = 1'b1;
    logic [31:0] c_din = '0;
    logic [7:0]  c_dout;
    logic        c_empty, c_ae, c_hf, c_af, c_rf, c_full, c_pw, c_err;
    logic [2:0]  c_cnt;

    logic [7:0]  qa[$];
    logic [31:0] qb[$];
    logic [7:0]  qc[$];

    kw_asym_fifo_s1 #(.DATA_I_WIDTH(8), .DATA_O_WIDTH(8), .DEPTH(4), .AE_LEVEL(1),
                      .AF_LEVEL(1), .ERR_MODE(0), .WORD_ORDER(0)) u_a (
        .clock(clock), .reset_n(reset_n), .push_req_n(a_push_n), .pop_req_n(a_pop_n),
        .flush_n(a_flush_n), .data_in(a_din), .data_out(a_dout), .empty(a_empty),
        .almost_empty(a_ae), .half_full(a_hf), .almost_full(a_af), .ram_full(a_rf),
        .full(a_full), .part_wr(a_pw), .error(a_err), .word_count(a_cnt));

    kw_asym_fifo_s1 #(.DATA_I_WIDTH(8), .DATA_O_WIDTH(32), .DEPTH(4), .AE_LEVEL(1),
                      .AF_LEVEL(1), .ERR_MODE(0), .WORD_ORDER(0)) u_b (
        .clock(clock), .reset_n(reset_n), .push_req_n(b_push_n), .pop_req_n(b_pop_n),
        .flush_n(b_flush_n), .data_in(b_din), .data_out(b_dout), .empty(b_empty),
        .almost_empty(b_ae), .half_full(b_hf), .almost_full(b_af), .ram_full(b_rf),
        .full(b_full), .part_wr(b_pw), .error(b_err), .word_count(b_cnt));

    kw_asym_fifo_s1 #(.DATA_I_WIDTH(32), .DATA_O_WIDTH(8), .DEPTH(4), .AE_LEVEL(1),
                      .AF_LEVEL(1), .ERR_MODE(1), .WORD_ORDER(1)) u_c (
        .clock(clock), .reset_n(reset_n), .push_req_n(c_push_n), .pop_req_n(c_pop_n),
        .flush_n(c_flush_n), .data_in(c_din), .data_out(c_dout), .empty(c_empty),
        .almost_empty(c_ae), .half_full(c_hf), .almost_full(c_af), .ram_full(c_rf),
        .full(c_full), .part_wr(c_pw), .error(c_err), .word_count(c_cnt));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitors: an accepted pop presents the head word on data_out before the edge.
    always @(negedge clock) begin
        if (reset_n && !a_pop_n && !a_empty) begin
            if (qa.size() == 0) check("a_pop_unexpected", 64'(a_dout), 64'hDEAD);
            else check("a_pop_data", 64'(a_dout), 64'(qa.pop_front()));
        end
        if (reset_n && !b_pop_n && !b_empty) begin
            if (qb.size() == 0) check("b_pop_unexpected", 64'(b_dout), 64'hDEAD);
            else check("b_pop_data", 64'(b_dout), 64'(qb.pop_front()));
        end
        if (reset_n && !c_pop_n && !c_empty) begin
            if (qc.size() == 0) check("c_pop_unexpected", 64'(c_dout), 64'hDEAD);
            else check("c_pop_data", 64'(c_dout), 64'(qc.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  bv [4];
        logic [31:0] w;
        bv = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        w  = '0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        check("a_rst_empty", a_empty, 1);
        check("a_rst_ae", a_ae, 1);
        check("a_rst_full", {a_full, a_rf, a_af, a_hf, a_pw, a_err}, 0);
        check("a_rst_cnt", a_cnt, 0);
        check("a_rst_dout", a_dout, 0);
        check("b_rst_pw", b_pw, 0);

        // ---- plain FIFO: fill, push+pop at full, overflow, drain ----
        for (int i = 1; i <= 4; i++) begin
            a_push_n = 1'b0; a_din = 8'(i); qa.push_back(8'(i));
            step();
            if (i == 2) check("a_ae_at2", a_ae, 0);
        end
        a_push_n = 1'b1;
        check("a_full_cnt", a_cnt, 4);
        check("a_full_flags", {a_full, a_rf, a_af, a_hf, a_err}, 5'b11110);
        a_push_n = 1'b0; a_din = 8'h05; a_pop_n = 1'b0; qa.push_back(8'h05);
        step();
        a_push_n = 1'b1; a_pop_n = 1'b1;
        check("a_simul_cnt", a_cnt, 4);
        check("a_simul_err", a_err, 0);
        a_push_n = 1'b0; a_din = 8'h06;
        step();
        a_push_n = 1'b1;
        check("a_ovf_err", a_err, 1);
        check("a_ovf_cnt", a_cnt, 4);
        step();
        check("a_err_sticky", a_err, 1);
        a_pop_n = 1'b0;
        repeat (4) step();
        a_pop_n = 1'b1;
        check("a_drain_empty", a_empty, 1);
        check("a_drain_cnt", a_cnt, 0);
        check("a_drain_dout", a_dout, 0);
        check("a_q_drained", qa.size(), 0);

        // ---- packing: four bytes form one word, then flush of a partial word ----
        for (int i = 0; i < 4; i++) begin
            b_push_n = 1'b0; b_din = bv[i];
            if (i == 3) qb.push_back(32'hAABBCCDD);
            step();
            check("b_part_wr", b_pw, (i < 3) ? 1 : 0);
        end
        b_push_n = 1'b1;
        check("b_cnt1", b_cnt, 1);
        check("b_fwft", b_dout, 32'hAABBCCDD);
        b_push_n = 1'b0; b_din = 8'h11; step();
        b_din = 8'h22; step();
        b_push_n = 1'b1;
        check("b_pw_before_flush", b_pw, 1);
        b_flush_n = 1'b0; qb.push_back(32'h11220000);
        step();
        b_flush_n = 1'b1;
        check("b_flush_pw", b_pw, 0);
        check("b_flush_cnt", b_cnt, 2);
        check("b_flush_err", b_err, 0);
        b_pop_n = 1'b0;
        repeat (2) step();
        b_pop_n = 1'b1;
        check("b_drain_empty", b_empty, 1);

        // ---- packing at ram_full: partial push accepted, flush rejected ----
        b_push_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b_din = 8'(i);
            w = {w[23:0], 8'(i)};
            if (i % 4 == 3) qb.push_back(w);
            step();
        end
        b_din = 8'h50; step();
        b_push_n = 1'b1;
        check("b_rf_cnt", b_cnt, 4);
        check("b_rf_flags", {b_rf, b_pw, b_full, b_err}, 4'b1100);
        b_flush_n = 1'b0; step();
        b_flush_n = 1'b1;
        check("b_flush_rej_err", b_err, 1);
        check("b_flush_rej_state", {b_pw, b_cnt}, {1'b1, 3'd4});
        b_pop_n = 1'b0; step();
        b_pop_n = 1'b1;
        b_push_n = 1'b0; b_din = 8'h51; step();
        b_push_n = 1'b1;
        check("b_pre_rst_cnt", b_cnt, 3);

        // ---- asynchronous reset mid-stream (count 3, two bytes packed) ----
        #2;
        reset_n = 1'b0;
        #1;
        check("b_arst_empty", b_empty, 1);
        check("b_arst_pw", b_pw, 0);
        check("b_arst_err", b_err, 0);
        check("b_arst_cnt", b_cnt, 0);
        check("a_arst_err", a_err, 0);
        qa.delete(); qb.delete(); qc.delete();
        step();
        reset_n = 1'b1;

        // ---- unpacking, LSB-first ----
        c_push_n = 1'b0; c_din = 32'h44332211;
        qc.push_back(8'h11); qc.push_back(8'h22); qc.push_back(8'h33); qc.push_back(8'h44);
        step();
        c_push_n = 1'b1;
        check("c_cnt1", c_cnt, 1);
        check("c_fwft", c_dout, 8'h11);
        for (int i = 0; i < 4; i++) begin
            c_pop_n = 1'b0;
            step();
            check("c_cnt_pop", c_cnt, (i < 3) ? 1 : 0);
        end
        c_pop_n = 1'b1;
        check("c_empty", c_empty, 1);
        c_pop_n = 1'b0;
        #2;
        check("c_udf_err", c_err, 1);
        step();
        c_pop_n = 1'b1;
        #1;
        check("c_err_clears", c_err, 0);
        check("c_udf_cnt", c_cnt, 0);

        step();
        check("qa_final", qa.size(), 0);
        check("qb_final", qb.size(), 0);
        check("qc_final", qc.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
